// File: rtl/gps_pkg.sv
// Shared GPS L1 C/A constants, G2 phase-selector taps and LFSR helpers.
package gps_pkg;

  localparam int unsigned CA_LEN     = 1023;
  localparam int unsigned MS_PER_BIT = 20;
  localparam int unsigned NUM_PRN    = 36;

  typedef logic [35:0] ca_bus_t;

  // {ta, tb} G2 stage numbers (1..10); index 0 is PRN 1
  localparam logic [7:0] G2_TAPS [NUM_PRN] = '{
    8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29, 8'h3A,
    8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A, 8'h14, 8'h25,
    8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46, 8'h57, 8'h68, 8'h79,
    8'h8A, 8'h16, 8'h27, 8'h38, 8'h49, 8'h5A, 8'h4A, 8'h17, 8'h28
  };

  // Register bit i holds stage i+1; stage 1 receives the feedback.
  function automatic logic [9:0] g1_step(input logic [9:0] g1);
    return {g1[8:0], g1[9] ^ g1[2]};
  endfunction

  function automatic logic [9:0] g2_step(input logic [9:0] g2);
    return {g2[8:0], g2[9] ^ g2[8] ^ g2[7] ^ g2[5] ^ g2[2] ^ g2[1]};
  endfunction

  function automatic logic ca_chip(input logic [9:0] g1, input logic [9:0] g2,
                                   input logic [7:0] taps);
    logic [3:0] ta;
    logic [3:0] tb;
    ta = taps[7:4] - 4'd1;
    tb = taps[3:0] - 4'd1;
    return g1[9] ^ g2[ta] ^ g2[tb];
  endfunction

endpackage

// File: rtl/code_nco.sv
// Phase accumulator NCO with overflow carry; load overrides accumulation.
module code_nco #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [Width-1:0] load_phase,
  input  logic [Width-1:0] freq,
  output logic [Width-1:0] phase,
  output logic             carry
);

  logic [Width-1:0] acc_q, acc_d;
  logic [Width:0]   sum;

  // Next phase: load wins, otherwise accumulate while enabled; carry only on a real add
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, freq};
    acc_d = acc_q;
    carry = 1'b0;
    if (load) begin
      acc_d = load_phase;
    end else if (enable) begin
      acc_d = sum[Width-1:0];
      carry = sum[Width];
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign phase = acc_q;

endmodule

// File: rtl/ca_code_gen.sv
// Parallel GPS C/A Gold code generator for all PRNs, stepped by a code NCO,
// with chip, 1 ms epoch and 20 ms data-bit strobes.
module ca_code_gen #(
  parameter int unsigned NUM_PRN = 36,
  parameter int unsigned PHASE_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PHASE_W-1:0] chip_freq,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_phase,
  output logic [NUM_PRN-1:0] ca_seq,
  output logic [9:0]         chip_idx,
  output logic               chip_strobe,
  output logic               epoch,
  output logic [4:0]         ms_idx,
  output logic               bit_strobe
);

  import gps_pkg::CA_LEN;
  import gps_pkg::MS_PER_BIT;
  import gps_pkg::G2_TAPS;
  import gps_pkg::ca_bus_t;
  import gps_pkg::g1_step;
  import gps_pkg::g2_step;
  import gps_pkg::ca_chip;

  localparam logic [9:0] ChipLast = 10'(CA_LEN - 1);
  localparam logic [4:0] MsLast   = 5'(MS_PER_BIT - 1);

  logic [9:0] g1_q, g1_d, g2_q, g2_d;
  logic [9:0] chip_idx_q, chip_idx_d;
  logic [4:0] ms_idx_q, ms_idx_d;
  logic       chip_strobe_q, chip_strobe_d;
  logic       epoch_q, epoch_d;
  logic       bit_strobe_q, bit_strobe_d;

  logic [PHASE_W-1:0] nco_phase;
  logic               nco_carry;
  logic               unused_nco_phase;
  ca_bus_t            ca_bus;

  code_nco #(
    .Width (PHASE_W)
  ) u_nco (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .load_phase (load_phase),
    .freq       (chip_freq),
    .phase      (nco_phase),
    .carry      (nco_carry)
  );

  assign unused_nco_phase = ^nco_phase;

  // Chip sequencing: load restarts everything aligned; a carry advances one chip
  always_comb begin
    g1_d          = g1_q;
    g2_d          = g2_q;
    chip_idx_d    = chip_idx_q;
    ms_idx_d      = ms_idx_q;
    chip_strobe_d = 1'b0;
    epoch_d       = 1'b0;
    bit_strobe_d  = 1'b0;
    if (load) begin
      g1_d          = '1;
      g2_d          = '1;
      chip_idx_d    = '0;
      ms_idx_d      = '0;
      chip_strobe_d = 1'b1;
      epoch_d       = 1'b1;
      bit_strobe_d  = 1'b1;
    end else if (nco_carry) begin
      chip_strobe_d = 1'b1;
      if (chip_idx_q == ChipLast) begin
        // Explicit resync rather than trusting the natural LFSR period
        g1_d       = '1;
        g2_d       = '1;
        chip_idx_d = '0;
        epoch_d    = 1'b1;
        if (ms_idx_q == MsLast) begin
          ms_idx_d     = '0;
          bit_strobe_d = 1'b1;
        end else begin
          ms_idx_d = ms_idx_q + 5'd1;
        end
      end else begin
        g1_d       = g1_step(g1_q);
        g2_d       = g2_step(g2_q);
        chip_idx_d = chip_idx_q + 10'd1;
      end
    end
  end

  // Code state and strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g1_q          <= '1;
      g2_q          <= '1;
      chip_idx_q    <= '0;
      ms_idx_q      <= '0;
      chip_strobe_q <= 1'b0;
      epoch_q       <= 1'b0;
      bit_strobe_q  <= 1'b0;
    end else begin
      g1_q          <= g1_d;
      g2_q          <= g2_d;
      chip_idx_q    <= chip_idx_d;
      ms_idx_q      <= ms_idx_d;
      chip_strobe_q <= chip_strobe_d;
      epoch_q       <= epoch_d;
      bit_strobe_q  <= bit_strobe_d;
    end
  end

  // Per-PRN chips decoded from registered LFSR state only
  always_comb begin
    ca_bus = '0;
    for (int k = 0; k < 36; k++) begin
      ca_bus[k] = ca_chip(g1_q, g2_q, G2_TAPS[k]);
    end
  end

  assign ca_seq      = ca_bus[NUM_PRN-1:0];
  assign chip_idx    = chip_idx_q;
  assign ms_idx      = ms_idx_q;
  assign chip_strobe = chip_strobe_q;
  assign epoch       = epoch_q;
  assign bit_strobe  = bit_strobe_q;

endmodule

// File: tb/tb_ca_code_gen.sv
// Scoreboard bench for ca_code_gen: a chip-level reference model built from
// the ICD G2 delay table predicts every strobe; a negedge monitor checks them.
module tb_ca_code_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] chip_freq;
  logic        load;
  logic [31:0] load_phase;
  logic [35:0] ca_seq;
  logic [9:0]  chip_idx;
  logic        chip_strobe;
  logic        epoch;
  logic [4:0]  ms_idx;
  logic        bit_strobe;

  always #5 clk = ~clk;

  ca_code_gen #(
    .NUM_PRN (36),
    .PHASE_W (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .chip_freq   (chip_freq),
    .load        (load),
    .load_phase  (load_phase),
    .ca_seq      (ca_seq),
    .chip_idx    (chip_idx),
    .chip_strobe (chip_strobe),
    .epoch       (epoch),
    .ms_idx      (ms_idx),
    .bit_strobe  (bit_strobe)
  );

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ICD reference: G1/G2 output sequences and per-PRN G2 delays in chips
  bit g1s [1023];
  bit g2s [1023];
  int g2_delay [36] = '{5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256, 257, 258,
                        469, 470, 471, 472, 473, 474, 509, 512, 513, 514, 515, 516, 859, 860,
                        861, 862, 863, 950, 947, 948};

  function automatic void build_ref();
    for (int i = 0; i < 10; i++) begin
      g1s[i] = 1'b1;
      g2s[i] = 1'b1;
    end
    for (int n = 0; n + 10 < 1023; n++) begin
      g1s[n+10] = g1s[n+7] ^ g1s[n];
      g2s[n+10] = g2s[n+8] ^ g2s[n+7] ^ g2s[n+4] ^ g2s[n+2] ^ g2s[n+1] ^ g2s[n];
    end
  endfunction

  function automatic logic [35:0] ref_ca(input int chip);
    logic [35:0] r;
    for (int p = 0; p < 36; p++) begin
      r[p] = g1s[chip] ^ g2s[(chip + 1023 - g2_delay[p]) % 1023];
    end
    return r;
  endfunction

  typedef struct {
    int unsigned stamp;
    int          chip;
    logic [35:0] ca;
    bit          ep;
    bit          bs;
    int          ms;
  } exp_t;

  exp_t q[$];
  exp_t last;

  logic [31:0] m_acc;
  int          m_chip;
  int          m_ms;

  int          n_epoch = 0;
  int          n_bit = 0;
  bit          cap_en = 1'b0;
  logic [35:0] cap [10];

  function automatic exp_t reset_exp();
    exp_t e;
    e.stamp = 0;
    e.chip  = 0;
    e.ca    = 36'hF_FFFF_FFFF;
    e.ep    = 1'b0;
    e.bs    = 1'b0;
    e.ms    = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int chip, input bit ep, input bit bs, input int ms);
    exp_t e;
    e.stamp = cyc + 1;
    e.chip  = chip;
    e.ca    = ref_ca(chip);
    e.ep    = ep;
    e.bs    = bs;
    e.ms    = ms;
    q.push_back(e);
  endtask

  // One clock of stimulus; called and returns at posedge + 1.
  task automatic step(input logic en, input logic [31:0] fr, input logic ld,
                      input logic [31:0] lp);
    logic [32:0] s;
    bit          ep;
    bit          bs;
    enable     = en;
    chip_freq  = fr;
    load       = ld;
    load_phase = lp;
    chk("nco_phase", 64'(dut.nco_phase), 64'(m_acc));
    if (ld) begin
      m_acc  = lp;
      m_chip = 0;
      m_ms   = 0;
      push(0, 1'b1, 1'b1, 0);
    end else if (en) begin
      s     = {1'b0, m_acc} + {1'b0, fr};
      m_acc = s[31:0];
      if (s[32]) begin
        m_chip = (m_chip + 1) % 1023;
        ep     = (m_chip == 0);
        bs     = 1'b0;
        if (ep) begin
          m_ms = (m_ms + 1) % 20;
          bs   = (m_ms == 0);
        end
        push(m_chip, ep, bs, m_ms);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare on every chip_strobe; otherwise outputs must hold
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (chip_strobe === 1'b1) begin
        chk("strobe_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("strobe_cycle", 64'(cyc), 64'(e.stamp));
          chk("chip_idx", 64'(chip_idx), 64'(e.chip));
          chk("ca_seq", 64'(ca_seq), 64'(e.ca));
          chk("epoch", 64'(epoch), 64'(e.ep));
          chk("bit_strobe", 64'(bit_strobe), 64'(e.bs));
          chk("ms_idx", 64'(ms_idx), 64'(e.ms));
          if (e.ep) chk("epoch_ca_all_ones", 64'(ca_seq), 64'h0F_FFFF_FFFF);
          if (cap_en && e.chip < 10) cap[e.chip] = ca_seq;
          last = e;
        end
        n_epoch += int'(epoch);
        n_bit   += int'(bit_strobe);
      end else begin
        chk("idle_side_strobes", 64'({epoch, bit_strobe}), 64'd0);
        chk("hold_chip_idx", 64'(chip_idx), 64'(last.chip));
        chk("hold_ca_seq", 64'(ca_seq), 64'(last.ca));
        chk("hold_ms_idx", 64'(ms_idx), 64'(last.ms));
        if (q.size() != 0 && q[0].stamp <= cyc) begin
          chk("chip_strobe_when_due", 64'(chip_strobe), 64'd1);
          last = q.pop_front();
        end
      end
    end
  end

  initial begin
    logic [9:0] gold [4];
    logic [9:0] w;
    int         len;
    int         sel;
    logic [31:0] fr;

    gold = '{10'o1440, 10'o1620, 10'o1710, 10'o1744};
    build_ref();
    rst_n      = 1'b0;
    enable     = 1'b0;
    load       = 1'b0;
    chip_freq  = '0;
    load_phase = '0;
    m_acc      = '0;
    m_chip     = 0;
    m_ms       = 0;
    last       = reset_exp();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_chip_idx", 64'(chip_idx), 64'd0);
    chk("reset_ca_seq", 64'(ca_seq), 64'h0F_FFFF_FFFF);
    chk("reset_strobes", 64'({chip_strobe, epoch, bit_strobe}), 64'd0);
    chk("reset_ms_idx", 64'(ms_idx), 64'd0);
    cap[0] = ca_seq;
    rst_n  = 1'b1;

    // Half-rate chipping: first 10 chips of PRN1..4 against ICD octal values
    cap_en = 1'b1;
    repeat (24) step(1'b1, 32'h8000_0000, 1'b0, 32'h0);
    cap_en = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int n = 0; n < 10; n++) w[9-n] = cap[n][p];
      chk($sformatf("prn%0d_first10", p + 1), 64'(w), 64'(gold[p]));
    end

    // Full-rate run over 20 code periods plus 5 chips, starting from a load
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    n_epoch = 0;
    n_bit   = 0;
    repeat (20 * 1023 + 5) step(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0);
    chk("epoch_count", 64'(n_epoch), 64'd20);
    chk("bit_strobe_count", 64'(n_bit), 64'd1);

    // Load mid-code at chip 500, then quarter-rate chipping
    for (int i = 0; i < 1100 && m_chip != 500; i++) step(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    step(1'b1, 32'h4000_0000, 1'b1, 32'h4000_0000);
    repeat (10) step(1'b1, 32'h4000_0000, 1'b0, 32'h0);

    // Load landing on the cycle a natural wrap would occur
    for (int i = 0; i < 1100 && m_chip != 1022; i++) step(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678);
    repeat (5) step(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);

    // Pause at chip 700 and resume
    for (int i = 0; i < 1100 && m_chip != 700; i++) step(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    repeat (10) step(1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0);
    repeat (20) step(1'b1, 32'h9000_0000, 1'b0, 32'h0);

    // Randomised segments: rate, enable gaps and occasional loads
    repeat (150) begin
      sel = int'($urandom_range(3, 0));
      case (sel)
        0:       fr = $urandom;
        1:       fr = 32'hFFFF_FFFF - $urandom_range(1000, 0);
        2:       fr = 32'h0;
        default: fr = 32'h8000_0000 + $urandom_range(1000, 0);
      endcase
      len = int'($urandom_range(40, 1));
      for (int i = 0; i < len; i++) begin
        step(($urandom_range(7, 0) != 0), fr, ($urandom_range(199, 0) == 0), $urandom);
      end
    end

    // Asynchronous reset between edges while a load is being requested
    enable     = 1'b1;
    load       = 1'b1;
    load_phase = $urandom;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_chip_idx", 64'(chip_idx), 64'd0);
    chk("async_rst_ca_seq", 64'(ca_seq), 64'h0F_FFFF_FFFF);
    chk("async_rst_strobes", 64'({chip_strobe, epoch, bit_strobe}), 64'd0);
    chk("async_rst_ms_idx", 64'(ms_idx), 64'd0);
    chk("async_rst_phase", 64'(dut.nco_phase), 64'd0);
    load   = 1'b0;
    enable = 1'b0;
    q.delete();
    last   = reset_exp();
    m_acc  = '0;
    m_chip = 0;
    m_ms   = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) step(1'b1, 32'hC000_0000, 1'b0, 32'h0);

    repeat (4) step(1'b0, 32'h0, 1'b0, 32'h0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ca_code_gen.md
Name: ca_code_gen

Overview:
- Generates the GPS L1 C/A Gold codes for all 36 PRNs in parallel, advanced by a 32-bit code NCO.
- Drives the ca_seq[35:0] bus consumed by every sat_chan instance. Each channel's ca_sel picks its PRN bit.
- Also produces chip, 1 ms code-epoch and 20 ms data-bit strobes for downstream navigation-data modulation.

Parameters:
- NUM_PRN, 36, number of PRN outputs (bit k = PRN k+1).
- PHASE_W, 32, code NCO accumulator width.

Ports:
- clk  in  1  system sample clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  advance NCO/code when high; hold all state when low.
- chip_freq  in  32  code NCO increment = f_chip/f_clk * 2^32, Doppler-adjusted by software.
- load  in  1  single-cycle synchronous restart request.
- load_phase  in  32  NCO accumulator value applied on load.
- ca_seq  out  36  current chip of each PRN; 1 = multiply by -1, 0 = +1.
- chip_idx  out  10  current chip index 0..1022.
- chip_strobe  out  1  one-cycle pulse: ca_seq/chip_idx changed this cycle.
- epoch  out  1  one-cycle pulse coincident with chip_strobe when chip_idx wraps to 0.
- ms_idx  out  5  code epoch count within data bit, 0..19.
- bit_strobe  out  1  one-cycle pulse coincident with epoch when ms_idx wraps to 0.

Behaviour:
- Reset (async assert, sync release):
  - acc=0, G1=G2=10'h3FF, chip_idx=0, ms_idx=0.
  - All strobes 0.
  - ca_seq=36'hF_FFFF_FFFF (chip 0 of every PRN is 1).
- G1 polynomial 1+x^3+x^10; G2 polynomial 1+x^2+x^3+x^6+x^8+x^9+x^10. Both shift once per chip.
- ca_seq[k] = G1[10] XOR G2[ta_k] XOR G2[tb_k], taps from G2_TAPS per IS-GPS-200 phase-selector table.
- ca_seq is a pure function of registered LFSR state. There is no combinational path from any input.
- Code NCO:
  - Each enabled cycle: {carry,acc} <= acc + chip_freq (PHASE_W+1 bit add).
  - Carry=1 advances one chip at the same edge. The new ca_seq, chip_idx and chip_strobe are visible in the following cycle (latency 1 from the carry-producing cycle).
  - At most one chip per cycle; chip_freq=0 never advances.
- Chip wrap:
  - When chip_idx=1022 advances, chip_idx<=0 and both LFSRs are forced to all-ones (resync, not relying on the natural period). epoch=1.
  - ms_idx increments on epoch. At 19, ms_idx wraps to 0 and bit_strobe=1.
- enable=0:
  - acc, LFSRs, counters hold.
  - Strobes forced 0.
  - Outputs keep their last value.
- load=1 (priority over enable):
  - acc<=load_phase; LFSRs<=all-ones; chip_idx<=0; ms_idx<=0.
  - chip_strobe<=1, epoch<=1, bit_strobe<=1, so all sat_chans restart aligned.
  - No NCO add occurs that cycle.
- load coincident with a natural wrap: load wins. Single pulse on each strobe, no double count.
- Reset mid-operation: immediate return to reset values regardless of the enable or load state.

Decomposition:
- Package gps_pkg:
  - CA_LEN=1023, MS_PER_BIT=20, NUM_PRN=36.
  - G2_TAPS: a 36-entry array of 4-bit tap-index pairs.
  - typedef ca_bus_t (logic[35:0]).
- One sub-module, code_nco:
  - Accumulator plus carry output.
  - Load and enable inputs.
  - Reused later for the carrier NCO.

Test Plan:
- Reset release, enable=1, chip_freq=32'h8000_0000 -> chip_strobe every 2nd cycle; first strobe 2 cycles after the first enabled edge.
- Same stimulus, capture first 10 chips:
  - PRN1 = octal 1440 (1100100000).
  - PRN2 = 1620, PRN3 = 1710, PRN4 = 1744.
  - Bits after chip 0 compared against the ICD golden model for all 36 PRNs over 1023 chips.
- chip_freq=32'hFFFF_FFFF for 20*1023+5 chips -> epoch exactly every 1023 chip_strobes; ca_seq all-ones at each epoch; bit_strobe after the 20th epoch; ms_idx sequence 0..19,0.
- Mid-code (chip_idx=500) assert load with load_phase=32'h4000_0000 -> next cycle chip_idx=0, all three strobes=1, ca_seq=all-ones; with chip_freq=32'h4000_0000 next chip_strobe 3 cycles later.
- enable=0 for 10 cycles at chip_idx=700 -> no strobes; chip_idx, ca_seq, acc unchanged; resumes without losing phase.
- Assert rst_n=0 asynchronously between edges during load -> outputs at reset values before the next clk edge.
